// File: rtl/id_ex_stage_reg.sv
// ID/EX pipeline register with load-use hazard detection,
// branch flush and saturating stall/flush cycle counters.
module id_ex_stage_reg #(
  parameter int DATA_W = 32,
  parameter int REG_W  = 5,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              id_valid,
  input  logic [REG_W-1:0]  id_rs,
  input  logic [REG_W-1:0]  id_rt,
  input  logic [REG_W-1:0]  id_rd,
  input  logic              id_uses_rt,
  input  logic              id_regdst,
  input  logic [1:0]        id_regwrite,
  input  logic              id_memread,
  input  logic              id_memwrite,
  input  logic              id_memtoreg,
  input  logic              id_alusrc,
  input  logic [3:0]        id_aluop,
  input  logic [DATA_W-1:0] id_rs_data,
  input  logic [DATA_W-1:0] id_rt_data,
  input  logic [DATA_W-1:0] id_imm,
  input  logic              ex_flush,
  output logic              ex_valid,
  output logic              ex_memread,
  output logic              ex_memwrite,
  output logic              ex_memtoreg,
  output logic              ex_alusrc,
  output logic [1:0]        ex_regwrite,
  output logic [3:0]        ex_aluop,
  output logic [REG_W-1:0]  ex_rs,
  output logic [REG_W-1:0]  ex_rt,
  output logic [REG_W-1:0]  ex_regdest,
  output logic [DATA_W-1:0] ex_rs_data,
  output logic [DATA_W-1:0] ex_rt_data,
  output logic [DATA_W-1:0] ex_imm,
  output logic              pc_write,
  output logic              ifid_write,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  flush_cnt
);

  typedef struct packed {
    logic              valid;
    logic [1:0]        regwrite;
    logic              memread;
    logic              memwrite;
    logic              memtoreg;
    logic              alusrc;
    logic [3:0]        aluop;
    logic [REG_W-1:0]  rs;
    logic [REG_W-1:0]  rt;
    logic [REG_W-1:0]  regdest;
    logic [DATA_W-1:0] rs_data;
    logic [DATA_W-1:0] rt_data;
    logic [DATA_W-1:0] imm;
  } ex_t;

  ex_t              ex_q, ex_d;
  logic [CNT_W-1:0] stall_q, stall_d;
  logic [CNT_W-1:0] flush_q, flush_d;
  logic             hazard;
  logic             rs_hit, rt_hit;

  // Load in EX whose destination is read by the ID instruction
  always_comb begin
    rs_hit = (ex_q.regdest == id_rs);
    rt_hit = id_uses_rt & (ex_q.regdest == id_rt);
    hazard = ex_q.valid & ex_q.memread
           & (ex_q.regdest != '0)
           & (rs_hit | rt_hit) & id_valid;
  end

  // A flush redirects the PC, so it overrides the hold
  assign pc_write   = ~hazard | ex_flush;
  assign ifid_write = ~hazard | ex_flush;

  // Next EX contents: flush, then stall bubble, then capture
  always_comb begin
    ex_d    = '0;
    stall_d = stall_q;
    flush_d = flush_q;
    if (ex_flush) begin
      if (flush_q != '1) flush_d = flush_q + CNT_W'(1);
    end else if (hazard) begin
      if (stall_q != '1) stall_d = stall_q + CNT_W'(1);
    end else if (id_valid) begin
      ex_d.valid    = 1'b1;
      ex_d.regwrite = id_regwrite;
      ex_d.memread  = id_memread;
      ex_d.memwrite = id_memwrite;
      ex_d.memtoreg = id_memtoreg;
      ex_d.alusrc   = id_alusrc;
      ex_d.aluop    = id_aluop;
      ex_d.rs       = id_rs;
      ex_d.rt       = id_rt;
      ex_d.regdest  = id_regdst ? id_rd : id_rt;
      ex_d.rs_data  = id_rs_data;
      ex_d.rt_data  = id_rt_data;
      ex_d.imm      = id_imm;
    end
  end

  // Pipeline register and counters, synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      ex_q    <= '0;
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      ex_q    <= ex_d;
      stall_q <= stall_d;
      flush_q <= flush_d;
    end
  end

  assign ex_valid    = ex_q.valid;
  assign ex_regwrite = ex_q.regwrite;
  assign ex_memread  = ex_q.memread;
  assign ex_memwrite = ex_q.memwrite;
  assign ex_memtoreg = ex_q.memtoreg;
  assign ex_alusrc   = ex_q.alusrc;
  assign ex_aluop    = ex_q.aluop;
  assign ex_rs       = ex_q.rs;
  assign ex_rt       = ex_q.rt;
  assign ex_regdest  = ex_q.regdest;
  assign ex_rs_data  = ex_q.rs_data;
  assign ex_rt_data  = ex_q.rt_data;
  assign ex_imm      = ex_q.imm;
  assign stall_cnt   = stall_q;
  assign flush_cnt   = flush_q;

endmodule

// File: tb/tb_id_ex_stage_reg.sv
// Bench for id_ex_stage_reg: directed hazard/flush scenarios
// plus randomized traffic against a behavioural model.
module tb_id_ex_stage_reg;

  localparam int DW = 32;
  localparam int RW = 5;
  localparam int CW = 2;
  localparam int CMAX = (1 << CW) - 1;

  typedef struct packed {
    logic          v;
    logic [1:0]    rw;
    logic          mr;
    logic          mw;
    logic          mtr;
    logic          as;
    logic [3:0]    op;
    logic [RW-1:0] rs;
    logic [RW-1:0] rt;
    logic [RW-1:0] rd;
    logic [DW-1:0] a;
    logic [DW-1:0] b;
    logic [DW-1:0] imm;
  } ex_t;

  logic clk = 0;
  logic rst;
  logic id_valid, id_uses_rt, id_regdst;
  logic [RW-1:0] id_rs, id_rt, id_rd;
  logic [1:0] id_regwrite;
  logic id_memread, id_memwrite, id_memtoreg, id_alusrc;
  logic [3:0] id_aluop;
  logic [DW-1:0] id_rs_data, id_rt_data, id_imm;
  logic ex_flush;
  logic ex_valid, ex_memread, ex_memwrite, ex_memtoreg, ex_alusrc;
  logic [1:0] ex_regwrite;
  logic [3:0] ex_aluop;
  logic [RW-1:0] ex_rs, ex_rt, ex_regdest;
  logic [DW-1:0] ex_rs_data, ex_rt_data, ex_imm;
  logic pc_write, ifid_write;
  logic [CW-1:0] stall_cnt, flush_cnt;

  int n_cmp = 0;
  int n_err = 0;

  ex_t obs;
  ex_t m_ex;
  int  m_st, m_fl;

  assign obs = {ex_valid, ex_regwrite, ex_memread, ex_memwrite,
                ex_memtoreg, ex_alusrc, ex_aluop, ex_rs, ex_rt,
                ex_regdest, ex_rs_data, ex_rt_data, ex_imm};

  always #5 clk = ~clk;

  id_ex_stage_reg #(.DATA_W(DW), .REG_W(RW), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst),
    .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
    .id_rd(id_rd), .id_uses_rt(id_uses_rt),
    .id_regdst(id_regdst), .id_regwrite(id_regwrite),
    .id_memread(id_memread), .id_memwrite(id_memwrite),
    .id_memtoreg(id_memtoreg), .id_alusrc(id_alusrc),
    .id_aluop(id_aluop), .id_rs_data(id_rs_data),
    .id_rt_data(id_rt_data), .id_imm(id_imm),
    .ex_flush(ex_flush),
    .ex_valid(ex_valid), .ex_memread(ex_memread),
    .ex_memwrite(ex_memwrite), .ex_memtoreg(ex_memtoreg),
    .ex_alusrc(ex_alusrc), .ex_regwrite(ex_regwrite),
    .ex_aluop(ex_aluop), .ex_rs(ex_rs), .ex_rt(ex_rt),
    .ex_regdest(ex_regdest), .ex_rs_data(ex_rs_data),
    .ex_rt_data(ex_rt_data), .ex_imm(ex_imm),
    .pc_write(pc_write), .ifid_write(ifid_write),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  // What EX should hold if the ID slot advances this cycle
  function automatic ex_t captured();
    ex_t e;
    e = '0;
    if (id_valid) begin
      e.v   = 1'b1;
      e.rw  = id_regwrite;
      e.mr  = id_memread;
      e.mw  = id_memwrite;
      e.mtr = id_memtoreg;
      e.as  = id_alusrc;
      e.op  = id_aluop;
      e.rs  = id_rs;
      e.rt  = id_rt;
      e.rd  = id_regdst ? id_rd : id_rt;
      e.a   = id_rs_data;
      e.b   = id_rt_data;
      e.imm = id_imm;
    end
    return e;
  endfunction

  // A valid load in EX writing a register the ID instruction reads
  function automatic bit model_stall();
    bit reads;
    reads = (m_ex.rd == id_rs) ||
            (id_uses_rt && (m_ex.rd == id_rt));
    return id_valid && m_ex.v && m_ex.mr && m_ex.rd != 0 && reads;
  endfunction

  function automatic bit model_pcw();
    return ex_flush || !model_stall();
  endfunction

  task automatic tick();
    bit st;
    @(posedge clk);
    st = model_stall();
    if (rst) begin
      m_ex = '0; m_st = 0; m_fl = 0;
    end else if (ex_flush) begin
      m_ex = '0;
      if (m_fl < CMAX) m_fl++;
    end else if (st) begin
      m_ex = '0;
      if (m_st < CMAX) m_st++;
    end else begin
      m_ex = captured();
    end
    #1;
  endtask

  task automatic rand_fields();
    id_valid    = 1'b1;
    id_rs       = RW'($urandom);
    id_rt       = RW'($urandom);
    id_rd       = RW'($urandom);
    id_uses_rt  = 1'($urandom);
    id_regdst   = 1'($urandom);
    id_regwrite = 2'($urandom);
    id_memread  = 1'b0;
    id_memwrite = 1'($urandom);
    id_memtoreg = 1'($urandom);
    id_alusrc   = 1'($urandom);
    id_aluop    = 4'($urandom);
    id_rs_data  = $urandom;
    id_rt_data  = $urandom;
    id_imm      = $urandom;
    ex_flush    = 1'b0;
    rst         = 1'b0;
  endtask

  task automatic lw(input logic [RW-1:0] rt,
                    input logic [RW-1:0] rs);
    rand_fields();
    id_rs = rs; id_rt = rt; id_regdst = 1'b0;
    id_memread = 1'b1; id_memwrite = 1'b0;
    id_memtoreg = 1'b1; id_regwrite = 2'd1;
    id_uses_rt = 1'b0;
  endtask

  task automatic rtype(input logic [RW-1:0] rd,
                       input logic [RW-1:0] rs,
                       input logic [RW-1:0] rt);
    rand_fields();
    id_rs = rs; id_rt = rt; id_rd = rd;
    id_regdst = 1'b1; id_uses_rt = 1'b1;
    id_memwrite = 1'b0; id_memtoreg = 1'b0;
  endtask

  task automatic do_reset();
    rand_fields();
    id_valid = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rand_fields();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    id_valid = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (obs !== '0) begin
      n_err++; $display("FAIL reset_ex got %h want 0", obs);
    end
    n_cmp++;
    if (stall_cnt !== 0 || flush_cnt !== 0) begin
      n_err++;
      $display("FAIL reset_cnt got %0d/%0d want 0/0",
               stall_cnt, flush_cnt);
    end
    n_cmp++;
    if (pc_write !== 1'b1 || ifid_write !== 1'b1) begin
      n_err++;
      $display("FAIL reset_pcw got %b%b want 11",
               pc_write, ifid_write);
    end
  endtask

  task automatic test_load_use();
    do_reset();
    lw(5'd8, 5'd1);
    tick();
    rtype(5'd9, 5'd8, 5'd10);
    @(negedge clk);
    n_cmp++;
    if (pc_write !== 1'b0 || ifid_write !== 1'b0) begin
      n_err++;
      $display("FAIL lu_hold got %b%b want 00",
               pc_write, ifid_write);
    end
    tick();
    n_cmp++;
    if (obs !== '0 || stall_cnt !== 1) begin
      n_err++;
      $display("FAIL lu_bubble got %h cnt %0d want 0 cnt 1",
               obs, stall_cnt);
    end
    @(negedge clk);
    n_cmp++;
    if (pc_write !== 1'b1) begin
      n_err++; $display("FAIL lu_release got %b want 1", pc_write);
    end
    tick();
    n_cmp++;
    if (ex_valid !== 1'b1 || ex_rs !== 5'd8 || ex_regdest !== 5'd9
        || obs !== m_ex) begin
      n_err++;
      $display("FAIL lu_advance got v%b rs%0d rd%0d want v1 rs8 rd9",
               ex_valid, ex_rs, ex_regdest);
    end
  endtask

  task automatic test_store_rt();
    do_reset();
    lw(5'd8, 5'd2);
    tick();
    rand_fields();
    id_rs = 5'd3; id_rt = 5'd8; id_uses_rt = 1'b1;
    id_memwrite = 1'b1; id_regwrite = 2'd0;
    @(negedge clk);
    n_cmp++;
    if (pc_write !== 1'b0) begin
      n_err++; $display("FAIL sw_rt_stall got %b want 0", pc_write);
    end
    tick();
    tick();
    lw(5'd8, 5'd2);
    tick();
    rand_fields();
    id_rs = 5'd3; id_rt = 5'd8; id_uses_rt = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (pc_write !== 1'b1) begin
      n_err++; $display("FAIL sw_nouse got %b want 1", pc_write);
    end
    tick();
    n_cmp++;
    if (stall_cnt !== 1 || ex_valid !== 1'b1 || ex_rt !== 5'd8) begin
      n_err++;
      $display("FAIL sw_nouse_adv got cnt%0d v%b rt%0d want 1 1 8",
               stall_cnt, ex_valid, ex_rt);
    end
  endtask

  task automatic test_zero_reg();
    do_reset();
    lw(5'd0, 5'd4);
    tick();
    rtype(5'd6, 5'd0, 5'd0);
    @(negedge clk);
    n_cmp++;
    if (pc_write !== 1'b1) begin
      n_err++; $display("FAIL zero_pcw got %b want 1", pc_write);
    end
    tick();
    n_cmp++;
    if (stall_cnt !== 0 || ex_valid !== 1'b1) begin
      n_err++;
      $display("FAIL zero_cnt got cnt%0d v%b want 0 1",
               stall_cnt, ex_valid);
    end
  endtask

  task automatic test_flush_hazard();
    do_reset();
    lw(5'd8, 5'd1);
    tick();
    rtype(5'd9, 5'd8, 5'd10);
    ex_flush = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (pc_write !== 1'b1 || ifid_write !== 1'b1) begin
      n_err++;
      $display("FAIL fl_pcw got %b%b want 11", pc_write, ifid_write);
    end
    tick();
    ex_flush = 1'b0;
    n_cmp++;
    if (obs !== '0 || flush_cnt !== 1 || stall_cnt !== 0) begin
      n_err++;
      $display("FAIL fl_bubble got %h f%0d s%0d want 0 f1 s0",
               obs, flush_cnt, stall_cnt);
    end
  endtask

  task automatic test_back_to_back();
    logic [1:0] code;
    do_reset();
    for (int i = 0; i < 4; i++) begin
      rtype(5'd5, RW'(10 + i), RW'(20 + i));
      code = 2'(i);
      id_regwrite = code;
      tick();
      n_cmp++;
      if (ex_regdest !== 5'd5 || ex_regwrite !== code
          || obs !== m_ex) begin
        n_err++;
        $display("FAIL b2b_%0d got rd%0d rw%0d want rd5 rw%0d",
                 i, ex_regdest, ex_regwrite, code);
      end
    end
  endtask

  task automatic test_saturate();
    do_reset();
    lw(5'd8, 5'd8);
    tick();
    for (int i = 0; i < 10; i++) tick();
    n_cmp++;
    if (stall_cnt !== 2'd3) begin
      n_err++; $display("FAIL sat_cnt got %0d want 3", stall_cnt);
    end
    @(negedge clk);
    n_cmp++;
    if (pc_write !== 1'b0) begin
      n_err++; $display("FAIL sat_install got %b want 0", pc_write);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (obs !== '0 || stall_cnt !== 0 || pc_write !== 1'b1) begin
      n_err++;
      $display("FAIL sat_rst got %h s%0d p%b want 0 s0 p1",
               obs, stall_cnt, pc_write);
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 400; i++) begin
      rand_fields();
      id_valid   = ($urandom_range(0, 7) != 0);
      id_rs      = RW'($urandom_range(0, 3));
      id_rt      = RW'($urandom_range(0, 3));
      id_rd      = RW'($urandom_range(0, 3));
      id_memread = ($urandom_range(0, 2) == 0);
      ex_flush   = ($urandom_range(0, 9) == 0);
      rst        = ($urandom_range(0, 63) == 0);
      @(negedge clk);
      n_cmp++;
      if (pc_write !== model_pcw() || ifid_write !== model_pcw()) begin
        n_err++;
        $display("FAIL rnd_pcw_%0d got %b%b want %b",
                 i, pc_write, ifid_write, model_pcw());
      end
      tick();
      n_cmp++;
      if (obs !== m_ex || stall_cnt !== CW'(m_st)
          || flush_cnt !== CW'(m_fl)) begin
        n_err++;
        $display("FAIL rnd_ex_%0d got %h s%0d f%0d want %h s%0d f%0d",
                 i, obs, stall_cnt, flush_cnt, m_ex, m_st, m_fl);
      end
    end
  endtask

  initial begin
    m_ex = '0; m_st = 0; m_fl = 0;
    rand_fields();
    rst = 1'b1;
    test_reset();
    test_load_use();
    test_store_rt();
    test_zero_reg();
    test_flush_hazard();
    test_back_to_back();
    test_saturate();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule
